// File: rtl/seg7_digit_monitor.sv
// seg7_digit_monitor: filters a 7-seg bus, decodes accepted digits, measures period and flags bad/out-of-sequence codes
module seg7_digit_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                err_clr,
  output logic [3:0]          digit,
  output logic                digit_stb,
  output logic                digit_vld,
  output logic [PERIOD_W-1:0] period,
  output logic                period_vld,
  output logic                bad_pat,
  output logic                seq_err
);
  typedef enum logic [1:0] {EMPTY, FIRST, TRACK} state_t;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  state_t state, state_nxt;
  logic [6:0] seg_q, last;
  logic have_last;
  logic [7:0] cnt, cnt_nxt;
  logic [PERIOD_W-1:0] pcnt;
  logic [3:0] dec, exp_digit;
  logic legal, acc, good, bad, seq_bad;
  always_comb begin
    legal = 1'b1;
    dec = 4'd0;
    case (seg_q)
      7'b0111111: dec = 4'd0;
      7'b0000110: dec = 4'd1;
      7'b1011011: dec = 4'd2;
      7'b1001111: dec = 4'd3;
      7'b1100110: dec = 4'd4;
      7'b1101101: dec = 4'd5;
      7'b1111100: dec = 4'd6;
      7'b0000111: dec = 4'd7;
      7'b1111111: dec = 4'd8;
      7'b1100111: dec = 4'd9;
      default:    legal = 1'b0;
    endcase
  end
  always_comb begin
    cnt_nxt = (seg_in != seg_q) ? 8'd1 : (cnt == STABLE) ? cnt : cnt + 8'd1;
    acc = (cnt == STABLE) && (!have_last || seg_q != last);
    good = acc && legal;
    bad = acc && !legal;
    exp_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    seq_bad = good && state != EMPTY && dec != exp_digit;
    state_nxt = good ? ((state == EMPTY) ? FIRST : TRACK) : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      seg_q <= 7'd0;
      last <= 7'd0;
      have_last <= 1'b0;
      cnt <= 8'd0;
      pcnt <= '0;
      digit <= 4'd0;
      digit_stb <= 1'b0;
      digit_vld <= 1'b0;
      period <= '0;
      period_vld <= 1'b0;
      bad_pat <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state <= state_nxt;
      seg_q <= seg_in;
      cnt <= cnt_nxt;
      pcnt <= good ? PERIOD_W'(1) : (&pcnt) ? pcnt : pcnt + PERIOD_W'(1);
      digit_stb <= good;
      bad_pat <= bad | (bad_pat & ~err_clr);
      seq_err <= seq_bad | (seq_err & ~err_clr);
      if (acc) begin
        last <= seg_q;
        have_last <= 1'b1;
      end
      if (good) begin
        digit <= dec;
        digit_vld <= 1'b1;
      end
      if (good && state != EMPTY) begin
        period <= pcnt;
        period_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_digit_monitor.sv
// tb_seg7_digit_monitor: directed stimulus with a strobe scoreboard for seg7_digit_monitor
module tb_seg7_digit_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_clr = 1'b0;
  logic [6:0] seg_in = 7'd0;
  logic [3:0] digit, digit8;
  logic digit_stb, digit_vld, period_vld, bad_pat, seq_err;
  logic digit_stb8, digit_vld8, period_vld8, bad_pat8, seq_err8;
  logic [23:0] period;
  logic [7:0] period8;
  int n_chk = 0;
  int n_pass = 0;
  int n_stb = 0;
  typedef struct packed {
    logic [3:0]  d;
    logic        pv;
    logic [31:0] p;
  } exp_t;
  exp_t q[$];
  logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};
  seg7_digit_monitor #(.STABLE_CYCLES(4), .PERIOD_W(24)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .err_clr(err_clr),
    .digit(digit), .digit_stb(digit_stb), .digit_vld(digit_vld),
    .period(period), .period_vld(period_vld), .bad_pat(bad_pat), .seq_err(seq_err)
  );
  seg7_digit_monitor #(.STABLE_CYCLES(4), .PERIOD_W(8)) dut8 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .err_clr(err_clr),
    .digit(digit8), .digit_stb(digit_stb8), .digit_vld(digit_vld8),
    .period(period8), .period_vld(period_vld8), .bad_pat(bad_pat8), .seq_err(seq_err8)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int d, input logic pv, input int p);
    q.push_back({4'(d), pv, 32'(p)});
  endtask
  task automatic show(input int d);
    seg_in = pat[d];
  endtask
  task automatic clr_pulse();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset && digit_stb) begin
      n_stb++;
      check("stb_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("stb_digit", 32'(digit), 32'(e.d));
        check("stb_period_vld", 32'(period_vld), 32'(e.pv));
        check("stb_period", 32'(period), e.p);
      end
    end
  end
  initial begin
    show(0);
    step(3);
    check("rst_digit", 32'(digit), 0);
    check("rst_stb", 32'(digit_stb), 0);
    check("rst_vld", 32'(digit_vld), 0);
    check("rst_period", 32'(period), 0);
    check("rst_pvld", 32'(period_vld), 0);
    check("rst_bad", 32'(bad_pat), 0);
    check("rst_seq", 32'(seq_err), 0);
    push(0, 1'b0, 0);
    reset = 1'b0;
    step(4);
    check("t1_stb_early", 32'(digit_stb), 0);
    step(1);
    check("t1_stb", 32'(digit_stb), 1);
    check("t1_vld", 32'(digit_vld), 1);
    check("t1_pvld", 32'(period_vld), 0);
    step(15);
    for (int i = 1; i <= 10; i++) begin
      push(i % 10, 1'b1, 20);
      show(i % 10);
      step(20);
    end
    check("t2_nstb", 32'(n_stb), 11);
    check("t2_seq", 32'(seq_err), 0);
    check("t2_bad", 32'(bad_pat), 0);
    push(1, 1'b1, 20);
    show(1);
    step(20);
    show(2);
    step(2);
    show(1);
    step(10);
    check("t3_glitch2_digit", 32'(digit), 1);
    show(2);
    step(3);
    show(1);
    step(10);
    check("t3_glitch3_digit", 32'(digit), 1);
    check("t3_nstb", 32'(n_stb), 12);
    push(2, 1'b1, 45);
    show(2);
    step(4);
    check("t3_glitch4_stb_early", 32'(digit_stb), 0);
    push(3, 1'b1, 4);
    show(3);
    step(20);
    check("t3_seq", 32'(seq_err), 0);
    push(5, 1'b1, 20);
    show(5);
    step(20);
    check("t4_seq_set", 32'(seq_err), 1);
    clr_pulse();
    check("t4_seq_clr", 32'(seq_err), 0);
    push(7, 1'b1, 21);
    show(7);
    step(10);
    check("t4_seq_7", 32'(seq_err), 1);
    clr_pulse();
    check("t4_seq_clr2", 32'(seq_err), 0);
    step(9);
    push(2, 1'b1, 20);
    show(2);
    step(4);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_clr_race_stb", 32'(digit_stb), 1);
    check("t4_clr_race_seq", 32'(seq_err), 1);
    step(15);
    seg_in = 7'b1000000;
    step(10);
    check("t5_bad", 32'(bad_pat), 1);
    check("t5_digit", 32'(digit), 2);
    check("t5_nstb", 32'(n_stb), 17);
    push(0, 1'b1, 30);
    show(0);
    step(20);
    check("t5_bad_sticky", 32'(bad_pat), 1);
    check("t5_seq", 32'(seq_err), 1);
    clr_pulse();
    check("t5_bad_clr", 32'(bad_pat), 0);
    check("t5_seq_clr", 32'(seq_err), 0);
    seg_in = 7'b1000000;
    step(10);
    check("t5_bad2", 32'(bad_pat), 1);
    push(0, 1'b1, 31);
    show(0);
    step(20);
    check("t5_repeat_seq", 32'(seq_err), 1);
    check("t5_repeat_digit", 32'(digit), 0);
    push(1, 1'b1, 20);
    show(1);
    step(300);
    push(2, 1'b1, 300);
    show(2);
    step(5);
    check("t6_p8_period", 32'(period8), 255);
    check("t6_p8_pvld", 32'(period_vld8), 1);
    check("t6_p8_digit", 32'(digit8), 2);
    check("t6_p8_stb", 32'(digit_stb8), 1);
    check("t6_p8_vld", 32'(digit_vld8), 1);
    check("t6_p8_bad", 32'(bad_pat8), 1);
    check("t6_p8_seq", 32'(seq_err8), 1);
    step(15);
    show(3);
    step(2);
    reset = 1'b1;
    step(1);
    check("t6_rst_digit", 32'(digit), 0);
    check("t6_rst_vld", 32'(digit_vld), 0);
    check("t6_rst_period", 32'(period), 0);
    check("t6_rst_pvld", 32'(period_vld), 0);
    check("t6_rst_bad", 32'(bad_pat), 0);
    check("t6_rst_seq", 32'(seq_err), 0);
    check("t6_rst_p8", 32'(period8), 0);
    reset = 1'b0;
    push(3, 1'b0, 0);
    step(20);
    check("t6_first_seq", 32'(seq_err), 0);
    push(5, 1'b1, 20);
    show(5);
    step(20);
    check("t6_second_seq", 32'(seq_err), 1);
    check("t6_second_pvld", 32'(period_vld), 1);
    check("sb_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
